// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the pipelined adder family.
// Latency: none (package only).
// Backpressure: not applicable.
package adder_pkg;

  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;

  // True when the width/stage combination can be split into equal chunks.
  function automatic bit params_ok(input int n, input int s);
    return (n >= 2) && (s >= 1) && (s <= n) && ((n % s) == 0);
  endfunction

endpackage

// File: rtl/adder_pipe_nbit_if.sv
// Operand/result handshake bundle for adder_pipe_nbit.
// Latency: none (wiring only).
// Backpressure: out_ready from consumer, in_ready toward producer.
interface adder_pipe_nbit_if
  import adder_pkg::*;
#(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  op_e          op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;

  // Producer/consumer side (drives operands, accepts results).
  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/adder_nbit.sv
// Combinational N-bit adder with carry-in/carry-out; used as the chunk adder.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
module adder_nbit #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_cin};
endmodule

// File: rtl/adder_pipe_nbit.sv
// Pipelined N-bit add/subtract split into S carry-chained chunk stages, with signed overflow.
// Latency: S rising edges from accept to out_valid (no stall); 1 beat/cycle throughput.
// Backpressure: one global enable (!out_valid || out_ready) freezes every stage; in_ready equals it.
module adder_pipe_nbit
  import adder_pkg::*;
#(
  parameter int N = 8,
  parameter int S = 2
) (
  input logic             clk,
  input logic             rst_n,
  adder_pipe_nbit_if.slave bus
);
  localparam int W = N / S;

  if (!params_ok(N, S)) begin : g_param_err
    $error("adder_pipe_nbit: need N >= 2, 1 <= S <= N and N divisible by S");
  end

  logic w_en;
  logic w_last_v;

  // Bubbles advance like full beats, so a single enable keeps ordering strictly FIFO.
  assign w_en         = !w_last_v || bus.out_ready;
  assign bus.in_ready = w_en;

  for (genvar k = 0; k < S; k++) begin : g_stage
    // Width of the not-yet-added operand bits arriving at this stage.
    localparam int IN_W = N - k * W;

    logic [IN_W-1:0]      w_ra;
    logic [IN_W-1:0]      w_rb;
    logic                 w_pc;
    logic                 w_pv;
    logic [W-1:0]         w_chunk;
    logic                 w_co;
    logic [(k+1)*W-1:0]   w_sum_nxt;

    logic                 r_v;
    logic                 r_c;
    logic [(k+1)*W-1:0]   r_s;

    if (k == 0) begin : g_src
      // Subtraction is a + ~b + 1: invert B here and force the chain carry-in.
      assign w_ra      = bus.a;
      assign w_rb      = (bus.op == OP_SUB) ? ~bus.b : bus.b;
      assign w_pc      = (bus.op == OP_SUB) ? 1'b1 : bus.cin;
      assign w_pv      = bus.in_valid;
      assign w_sum_nxt = w_chunk;
    end else begin : g_src
      assign w_ra      = g_stage[k-1].g_rem.r_a;
      assign w_rb      = g_stage[k-1].g_rem.r_b;
      assign w_pc      = g_stage[k-1].r_c;
      assign w_pv      = g_stage[k-1].r_v;
      assign w_sum_nxt = {w_chunk, g_stage[k-1].r_s};
    end

    adder_nbit #(.N(W)) u_add (
      .i_a    (w_ra[W-1:0]),
      .i_b    (w_rb[W-1:0]),
      .i_cin  (w_pc),
      .o_sum  (w_chunk),
      .o_cout (w_co)
    );

    // Stage register: valid, chunk carry and the sum bits completed so far.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (w_en) begin
        r_v <= w_pv;
        r_c <= w_co;
        r_s <= w_sum_nxt;
      end
    end

    if (k < S - 1) begin : g_rem
      localparam int REM_W = IN_W - W;
      logic [REM_W-1:0] r_a;
      logic [REM_W-1:0] r_b;

      // Carry the untouched upper operand chunks forward to later stages.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_en) begin
          r_a <= w_ra[IN_W-1:W];
          r_b <= w_rb[IN_W-1:W];
        end
      end
    end else begin : g_last
      logic w_cmsb;
      logic r_ovf;

      // Carry into the MSB recovered from the MSB full-adder inputs and output.
      assign w_cmsb = w_ra[W-1] ^ w_rb[W-1] ^ w_chunk[W-1];

      // Signed overflow registered alongside the final sum so outputs are flop-driven.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_en) begin
          r_ovf <= w_cmsb ^ w_co;
        end
      end

      assign w_last_v      = r_v;
      assign bus.out_valid = r_v;
      assign bus.sum       = r_s;
      assign bus.cout      = r_c;
      assign bus.ovf       = r_ovf;
    end
  end

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Self-checking bench for adder_pipe_nbit (N=8, S=2) against an arithmetic scoreboard.
// Latency: checks S-edge accept-to-valid latency and 1 beat/cycle streaming.
// Backpressure: stalls, simultaneous release/accept, random valid/ready, mid-stream reset.
module tb_adder_pipe_nbit;
  import adder_pkg::*;

  localparam int N = 8;
  localparam int S = 2;

  typedef struct packed {
    logic [N-1:0] s;
    logic         c;
    logic         o;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adder_pipe_nbit_if #(.N(N)) bus ();

  adder_pipe_nbit #(.N(N), .S(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  res_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_acc = 0;
  int   n_xfer = 0;
  logic acc, xfer, have_exp;
  res_t got, expv;

  logic [7:0] d_a  [6] = '{8'hFF, 8'h10, 8'h80, 8'h7F, 8'h12, 8'h05};
  logic [7:0] d_b  [6] = '{8'h01, 8'h20, 8'h01, 8'h01, 8'h34, 8'h03};
  logic       d_ci [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic       d_op [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [7:0] d_s  [6] = '{8'h00, 8'hF0, 8'h7F, 8'h80, 8'h47, 8'h02};
  logic       d_co [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic       d_ov [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  // Reference: plain integer arithmetic, unsigned for sum/carry, signed range for overflow.
  function automatic res_t model(logic [N-1:0] a, logic [N-1:0] b, logic cin, op_e op);
    int   ua, ub, sa, sb, u, s;
    res_t r;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (op == OP_ADD) begin
      u   = ua + ub + int'(cin);
      s   = sa + sb + int'(cin);
      r.c = (u > (1 << N) - 1);
    end else begin
      u   = ua - ub;
      s   = sa - sb;
      r.c = (ua >= ub);
    end
    r.s = u[N-1:0];
    r.o = (s > (1 << (N - 1)) - 1) || (s < -(1 << (N - 1)));
    return r;
  endfunction

  // One clock: record handshakes at the falling edge, then advance past the rising edge.
  task automatic step();
    @(negedge clk);
    acc      = bus.in_valid && bus.in_ready;
    xfer     = bus.out_valid && bus.out_ready;
    have_exp = 1'b0;
    if (xfer) begin
      got = {bus.sum, bus.cout, bus.ovf};
      n_xfer++;
      if (q.size() > 0) begin
        expv     = q.pop_front();
        have_exp = 1'b1;
      end
    end
    if (acc) begin
      q.push_back(model(bus.a, bus.b, bus.cin, bus.op));
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beat();
    bus.a   = N'($urandom);
    bus.b   = N'($urandom);
    bus.cin = 1'($urandom_range(0, 1));
    bus.op  = op_e'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.op        = OP_ADD;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid); end
    n_vec++;
    if (bus.sum !== '0) begin n_bad++; $display("FAIL reset sum: got %h want 00", bus.sum); end
    n_vec++;
    if (bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      n_bad++; $display("FAIL reset cout/ovf: got %b/%b want 0/0", bus.cout, bus.ovf);
    end
    n_vec++;
    if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset in_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    int edges;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.a        = d_a[i];
      bus.b        = d_b[i];
      bus.cin      = d_ci[i];
      bus.op       = op_e'(d_op[i]);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      edges = 1;
      while (!bus.out_valid && edges < 10) begin
        step();
        edges++;
      end
      n_vec++;
      if (edges != S) begin n_bad++; $display("FAIL directed[%0d] latency: got %0d edges want %0d", i, edges, S); end
      step();
      n_vec++;
      if (!xfer) begin
        n_bad++; $display("FAIL directed[%0d] transfer: got none want one", i);
      end else if (got.s !== d_s[i] || got.c !== d_co[i] || got.o !== d_ov[i]) begin
        n_bad++;
        $display("FAIL directed[%0d] result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                 i, got.s, got.c, got.o, d_s[i], d_co[i], d_ov[i]);
      end
    end
  endtask

  task automatic test_stream();
    int x0;
    x0 = n_xfer;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      rand_beat();
      bus.in_valid = 1'b1;
      step();
      if (i >= S) begin
        n_vec++;
        if (!xfer) begin n_bad++; $display("FAIL stream throughput at %0d: got no transfer want one", i); end
      end
      if (xfer) begin
        n_vec++;
        if (!have_exp || got !== expv) begin
          n_bad++; $display("FAIL stream beat: got %h want %h (exp valid %b)", got, expv, have_exp);
        end
      end
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 20 && q.size() > 0; k++) begin
      step();
      if (xfer) begin
        n_vec++;
        if (!have_exp || got !== expv) begin
          n_bad++; $display("FAIL stream drain: got %h want %h (exp valid %b)", got, expv, have_exp);
        end
      end
    end
    n_vec++;
    if (n_xfer - x0 != 256) begin n_bad++; $display("FAIL stream count: got %0d results want 256", n_xfer - x0); end
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 10 && bus.in_ready; k++) begin
      rand_beat();
      step();
    end
    for (int c = 0; c < 5; c++) begin
      rand_beat();
      step();
      n_vec++;
      if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL stall in_ready cycle %0d: got %b want 0", c, bus.in_ready); end
      n_vec++;
      if (q.size() == 0 || bus.out_valid !== 1'b1 || {bus.sum, bus.cout, bus.ovf} !== q[0]) begin
        n_bad++;
        $display("FAIL stall hold cycle %0d: got v=%b %h want v=1 %h", c, bus.out_valid,
                 {bus.sum, bus.cout, bus.ovf}, (q.size() > 0) ? q[0] : res_t'('0));
      end
    end
    bus.out_ready = 1'b1;
    rand_beat();
    step();
    n_vec++;
    if (!(acc && xfer)) begin n_bad++; $display("FAIL stall release: got acc=%b xfer=%b want 1/1", acc, xfer); end
    n_vec++;
    if (!have_exp || got !== expv) begin n_bad++; $display("FAIL stall release beat: got %h want %h", got, expv); end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 20 && q.size() > 0; k++) begin
      step();
      if (xfer) begin
        n_vec++;
        if (!have_exp || got !== expv) begin n_bad++; $display("FAIL stall drain: got %h want %h", got, expv); end
      end
    end
    n_vec++;
    if (q.size() != 0) begin n_bad++; $display("FAIL stall lost beats: got %0d pending want 0", q.size()); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      rand_beat();
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
      if (xfer) begin
        n_vec++;
        if (!have_exp || got !== expv) begin n_bad++; $display("FAIL b2b beat %0d: got %h want %h", i, got, expv); end
      end
      if (bus.out_valid) begin
        n_vec++;
        if (q.size() == 0 || {bus.sum, bus.cout, bus.ovf} !== q[0]) begin
          n_bad++; $display("FAIL b2b head %0d: got %h want %h (pending %0d)", i, {bus.sum, bus.cout, bus.ovf},
                            (q.size() > 0) ? q[0] : res_t'('0), q.size());
        end
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20 && q.size() > 0; k++) begin
      step();
      if (xfer) begin
        n_vec++;
        if (!have_exp || got !== expv) begin n_bad++; $display("FAIL b2b drain: got %h want %h", got, expv); end
      end
    end
    n_vec++;
    if (n_acc != n_xfer) begin n_bad++; $display("FAIL b2b totals: got %0d out want %0d in", n_xfer, n_acc); end
  endtask

  task automatic test_reset_midstream();
    int edges;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_beat();
      bus.a        = 8'hC3 ^ N'(i);
      bus.in_valid = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL midreset out_valid: got %b want 0", bus.out_valid); end
    n_vec++;
    if (bus.sum !== '0 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      n_bad++; $display("FAIL midreset outputs: got sum=%h cout=%b ovf=%b want 0", bus.sum, bus.cout, bus.ovf);
    end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rand_beat();
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    edges = 1;
    while (!bus.out_valid && edges < 10) begin
      step();
      edges++;
    end
    n_vec++;
    if (edges != S) begin n_bad++; $display("FAIL midreset latency: got %0d edges want %0d", edges, S); end
    step();
    n_vec++;
    if (!xfer || !have_exp || got !== expv) begin
      n_bad++; $display("FAIL midreset first beat: got xfer=%b %h want %h", xfer, got, expv);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_vec++;
      if (xfer) begin n_bad++; $display("FAIL midreset stale beat: got %h want none", got); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream();
    test_stall();
    test_back_to_back();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/adder_pipe_nbit.md
# adder_pipe_nbit

Pipelined, parametrised successor to the combinational `adder_nbit`. It splits an N-bit add or subtract into S carry-chained chunk stages with registers between them, so wide operands close timing at full clock rate. A valid/ready handshake on both sides supports back-to-back throughput and downstream backpressure. It also reports signed overflow, which `adder_nbit` does not.

## Interface
- `N`, default 8: operand/result width; N ≥ 2.
- `S`, default 2: pipeline stages = carry chunks; 1 ≤ S ≤ N, N % S == 0 (elaboration error otherwise).
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `in_valid`  in  1: operand beat present.
- `in_ready`  out  1: block accepts a beat this cycle.
- `a`  in  N: operand A, unsigned/two's complement.
- `b`  in  N: operand B.
- `cin`  in  1: carry-in, used only for ADD.
- `op`  in  1: `OP_ADD`=0 computes a+b+cin; `OP_SUB`=1 computes a+~b+1, ignoring cin.
- `out_valid`  out  1: result beat present.
- `out_ready`  in  1: consumer takes result this cycle.
- `sum`  out  N: result, modulo 2^N.
- `cout`  out  1: carry-out of MSB (SUB: 1 = no borrow).
- `ovf`  out  1: signed overflow, i.e. carry into MSB XOR carry out of MSB.

## Operation
- Chunk width W = N/S. Stage k (0..S-1) adds bits [k·W +: W] of the effective A/B, using the carry registered by stage k-1. Stage 0 carry-in is cin for ADD and 1 for SUB.
- Effective B is b for ADD and ~b for SUB, inverted at the input before stage 0.
- Each stage register holds:
  - valid bit;
  - remaining unprocessed upper A/B chunks;
  - completed lower sum chunks;
  - the single carry bit.
- The final stage also registers `ovf` and `cout`.
- Global advance enable: en = !out_valid || out_ready. When en=1, every stage register loads from its predecessor, and stage 0 loads {in_valid, operands}. When en=0, all stages hold.
- in_ready = en (combinational from out_valid/out_ready only; never from in_valid).
- A beat is accepted when in_valid && in_ready. A result transfers when out_valid && out_ready.
- Bubbles are not collapsed. An empty stage advances like a full one, so ordering is strictly FIFO.
- The block never drops, duplicates or reorders beats.
- S=1 degenerates to a single registered `adder_nbit` with the same handshake.

## Timing
- Reset (rst_n=0, asynchronous): all valid bits, data, carries, `sum`, `cout` and `ovf` = 0; `out_valid`=0.
  - in_ready=1 while out_ready is ignored, because out_valid=0.
- Any beats in flight when reset asserts are discarded. The first cycle after deassert behaves as a fresh pipeline.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+S-1, i.e. S rising edges after acceptance, when there is no stall.
- Throughput: 1 beat/cycle while out_ready=1.
- Stall: out_valid=1 && out_ready=0 gives in_ready=0. `sum`/`cout`/`ovf`/`out_valid` stay stable until the transfer.
- Stall release:
  - out_ready=1 with in_valid=1 in the same cycle: the output transfer and the new accept happen on the same edge.
  - Pipeline full and output transferring: accept still allowed, because en=1.
- Outputs are driven directly from final-stage registers; no combinational path from inputs to `sum`/`cout`/`ovf`/`out_valid`.
- Wrap-around: sum is modulo 2^N. 0xFF+0x01 → 0x00, cout=1.

## Structure
- Shared package `adder_pkg`:
  - `typedef enum logic {OP_ADD=1'b0, OP_SUB=1'b1} op_e`;
  - parameter-check macro or function for N % S.
- Sub-module: existing `adder_nbit #(.N(W))`, instantiated once per stage as the chunk adder via a generate loop.
  - The MSB-chunk instance also exposes carry-into-MSB for `ovf`, computed in the wrapper as a ^ b ^ sum at the MSB.
- Pipeline registers live in the top module, built from a generate loop over S.

## Test plan
- N=8, S=2, ADD a=0xFF b=0x01 cin=0, out_ready=1 → after 2 edges: out_valid=1, sum=0x00, cout=1, ovf=0.
- SUB a=0x10 b=0x20 → sum=0xF0, cout=0, ovf=0. SUB a=0x80 b=0x01 → sum=0x7F, cout=1, ovf=1.
- ADD a=0x7F b=0x01 cin=0 → sum=0x80, cout=0, ovf=1. ADD a=0x12 b=0x34 cin=1 → sum=0x47.
- Stream 256 random beats with in_valid=1 and out_ready=1 → one result per cycle in order; every result matches a scoreboard of (a+b+cin) mod 256 for ADD and (a−b) mod 256 for SUB.
- Hold out_ready=0 for 5 cycles with the pipe full → in_ready=0 and outputs stable. On release, results drain in order with no loss.
- Assert rst_n=0 mid-stream with 2 beats in flight → out_valid=0 and sum=0 immediately (asynchronous). After deassert, the first new beat emerges S edges after accept and no stale beat appears.
